// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: inst SRAM-like request/response channel plus the decode hand-off.
// master = fetch stage, slave = memory/decode side.
interface if_fetch_queue_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  modport master (
    output inst_sram_req, inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, ds_allowin
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, ds_allowin
  );
endinterface

// File: rtl/if_fetch_queue.sv
// LoongArch instruction-fetch stage: multiple outstanding SRAM requests, in-order
// instruction buffer, and per-request kill tags so redirects never wait for drains.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned IBUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  if_fetch_queue_if.master           fs,
  input  logic                       br_stall,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  input  logic                       ertn_flush,
  input  logic [31:0]                ertn_entry,
  input  logic                       wb_ex,
  input  logic [31:0]                ex_entry,
  output logic [$clog2(MAX_OUTST):0] outst_cnt
);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned IW = $clog2(IBUF_DEPTH);
  localparam int unsigned BW = IW + 1;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;

  logic [31:0]          r_pend_pc [MAX_OUTST];
  logic [MAX_OUTST-1:0] r_pend_kill;
  logic [PW-1:0]        r_phead;
  logic [PW-1:0]        r_ptail;
  logic [CW-1:0]        r_pend_cnt;

  logic [64:0]   r_ibuf [IBUF_DEPTH];
  logic [IW-1:0] r_ihead;
  logic [IW-1:0] r_itail;
  logic [BW-1:0] r_ib_cnt;

  logic          w_redir;
  logic [31:0]   w_target;
  logic [31:0]   w_used;
  logic          w_req;
  logic          w_push;
  logic          w_resp;
  logic          w_resp_keep;
  logic          w_adef;
  logic          w_ib_push;
  logic [64:0]   w_ib_data;
  logic          w_valid;
  logic          w_ib_pop;

  assign w_redir = wb_ex | ertn_flush | br_taken;

  always_comb begin
    w_target = br_target;
    if (wb_ex)
      w_target = ex_entry;
    else if (ertn_flush)
      w_target = ertn_entry;
  end

  // Credits: every in-flight request already owns an ibuf slot, so responses never overflow.
  assign w_used = 32'(r_pend_cnt) + 32'(r_ib_cnt);
  assign w_req  = resetn & (r_state == S_RUN) & ~w_redir & (r_fetch_pc[1:0] == 2'b00)
                & (32'(r_pend_cnt) < MAX_OUTST) & (w_used < IBUF_DEPTH);
  assign w_push = w_req & fs.inst_sram_addr_ok;

  assign w_resp      = fs.inst_sram_data_ok & (r_pend_cnt != '0);
  assign w_resp_keep = w_resp & ~r_pend_kill[r_phead] & ~w_redir;

  assign w_adef = (r_state == S_RUN) & (r_fetch_pc[1:0] != 2'b00) & ~w_redir
                & (r_pend_cnt == '0) & (32'(r_ib_cnt) < IBUF_DEPTH);

  assign w_ib_push = w_resp_keep | w_adef;
  assign w_ib_data = w_adef ? {1'b1, 32'h0, r_fetch_pc}
                            : {1'b0, fs.inst_sram_rdata, r_pend_pc[r_phead]};
  assign w_valid   = (r_ib_cnt != '0) & ~w_redir;
  assign w_ib_pop  = w_valid & fs.ds_allowin;

  always_comb begin
    w_state_next = r_state;
    if (w_redir) begin
      w_state_next = br_stall ? S_STALL : S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_adef)
            w_state_next = S_HALT;
          else if (br_stall)
            w_state_next = S_STALL;
        end
        S_STALL: if (!br_stall) w_state_next = S_RUN;
        S_HALT:  w_state_next = S_HALT;
        default: w_state_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      r_state <= S_RUN;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      r_fetch_pc <= RESET_PC;
    else if (w_redir)
      r_fetch_pc <= w_target;
    else if (w_push)
      r_fetch_pc <= r_fetch_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_phead    <= '0;
      r_ptail    <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_push)
        r_ptail <= (r_ptail == PW'(MAX_OUTST - 1)) ? '0 : r_ptail + 1'b1;
      if (w_resp)
        r_phead <= (r_phead == PW'(MAX_OUTST - 1)) ? '0 : r_phead + 1'b1;
      r_pend_cnt <= r_pend_cnt + CW'(w_push) - CW'(w_resp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_pend_pc[r_ptail] <= r_fetch_pc;
  end

  // A redirect never coincides with a push, so the kill sweep can tag every slot.
  generate
    for (genvar gi = 0; gi < MAX_OUTST; gi++) begin : g_kill
      always_ff @(posedge clk) begin
        if (!resetn)
          r_pend_kill[gi] <= 1'b0;
        else if (w_push && (r_ptail == PW'(gi)))
          r_pend_kill[gi] <= 1'b0;
        else if (w_redir)
          r_pend_kill[gi] <= 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_ib_push)
      r_ibuf[r_itail] <= w_ib_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn || w_redir) begin
      r_ihead  <= '0;
      r_itail  <= '0;
      r_ib_cnt <= '0;
    end else begin
      if (w_ib_push)
        r_itail <= r_itail + 1'b1;
      if (w_ib_pop)
        r_ihead <= r_ihead + 1'b1;
      r_ib_cnt <= r_ib_cnt + BW'(w_ib_push) - BW'(w_ib_pop);
    end
  end

  assign fs.inst_sram_req  = w_req;
  assign fs.inst_sram_addr = r_fetch_pc;
  assign fs.fs_to_ds_valid = w_valid;
  assign fs.fs_to_ds_bus   = r_ibuf[r_ihead];
  assign outst_cnt         = r_pend_cnt;

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    !(fs.inst_sram_data_ok && (r_pend_cnt == '0)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order SRAM responder, table-driven fill/drain vectors,
// directed redirect/ADEF sequences and a randomized run against a stream-level model.
module tb_if_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int MAX_OUTST  = 4;
  localparam int IBUF_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic        br_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        ertn_flush = 1'b0;
  logic [31:0] ertn_entry = '0;
  logic        wb_ex = 1'b0;
  logic [31:0] ex_entry = '0;
  logic [2:0]  outst_cnt;

  if_fetch_queue_if fif ();

  if_fetch_queue #(
    .RESET_PC  (RESET_PC),
    .MAX_OUTST (MAX_OUTST),
    .IBUF_DEPTH(IBUF_DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .fs        (fif),
    .br_stall  (br_stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .ertn_flush(ertn_flush),
    .ertn_entry(ertn_entry),
    .wb_ex     (wb_ex),
    .ex_entry  (ex_entry),
    .outst_cnt (outst_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // SRAM model: accepted addresses with their response cycle, answered strictly in order
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat_min = 1, lat_max = 1, aok_pct = 100;

  // Stream-level reference state
  logic [31:0] exp_issue, exp_deliv;
  bit          halted, prev_stall;
  int          deliv_cnt, acc_cnt, max_outst;
  bit          got_acc, got_hs;
  logic [31:0] first_acc, first_pc;
  logic        first_adef;

  logic        s_req, s_valid, s_aok, s_dok;
  logic [31:0] s_addr;
  logic [64:0] s_bus;
  logic [2:0]  s_outst;

  typedef struct {
    logic        allowin;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    int          outst;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'ha5c30f96;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive SRAM side, sample mid-cycle, update model, advance to posedge+1.
  task automatic tick();
    logic        redir, hs, acc, adef_exp;
    logic [31:0] tgt;
    fif.inst_sram_addr_ok = ($urandom_range(99) < aok_pct);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      fif.inst_sram_data_ok = 1'b1;
      fif.inst_sram_rdata   = mem_word(mq_addr[0]);
    end else begin
      fif.inst_sram_data_ok = 1'b0;
      fif.inst_sram_rdata   = $urandom;
    end
    #2;
    s_req = fif.inst_sram_req;   s_addr  = fif.inst_sram_addr;
    s_valid = fif.fs_to_ds_valid; s_bus  = fif.fs_to_ds_bus;
    s_aok = fif.inst_sram_addr_ok; s_dok = fif.inst_sram_data_ok;
    s_outst = outst_cnt;
    if (resetn) begin
      redir = wb_ex | ertn_flush | br_taken;
      tgt   = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
      hs    = s_valid & fif.ds_allowin;
      acc   = s_req & s_aok;
      if (int'(s_outst) > max_outst) max_outst = int'(s_outst);
      check("outst_cnt", s_outst, mq_addr.size());
      if (prev_stall) check("req_in_stall", s_req, 1'b0);
      if (exp_issue[1:0] != 2'b00 || halted) check("req_blocked", s_req, 1'b0);
      if (mq_addr.size() >= MAX_OUTST) check("req_at_max", s_req, 1'b0);
      if (redir) begin
        check("valid_on_redir", s_valid, 1'b0);
        check("req_on_redir", s_req, 1'b0);
      end
      if (acc) begin
        check("issue_addr", s_addr, exp_issue);
        if (!got_acc) begin first_acc = s_addr; got_acc = 1'b1; end
        exp_issue += 32'd4;
        acc_cnt++;
        mq_addr.push_back(s_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      if (hs) begin
        $display("deliver pc=%h inst=%h adef=%0d cycle=%0d", s_bus[31:0], s_bus[63:32], s_bus[64], cyc);
        if (!got_hs) begin first_pc = s_bus[31:0]; first_adef = s_bus[64]; got_hs = 1'b1; end
        if (halted) begin
          check("deliver_while_halted", s_valid, 1'b0);
        end else begin
          adef_exp = (exp_deliv[1:0] != 2'b00);
          check("deliver_pc", s_bus[31:0], exp_deliv);
          check("deliver_adef", s_bus[64], adef_exp);
          check("deliver_inst", s_bus[63:32], adef_exp ? 32'h0 : mem_word(exp_deliv));
          if (adef_exp) halted = 1'b1;
          exp_deliv += 32'd4;
        end
        deliv_cnt++;
      end
      if (s_dok) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (redir) begin
        exp_issue = tgt; exp_deliv = tgt; halted = 1'b0;
        got_acc = 1'b0; got_hs = 1'b0;
        first_acc = 32'hffffffff; first_pc = 32'hffffffff; first_adef = 1'bx;
      end
      prev_stall = br_stall;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0; br_stall = 1'b0; br_taken = 1'b0; ertn_flush = 1'b0; wb_ex = 1'b0;
    mq_addr.delete(); mq_due.delete();
    run(3);
    check("rst_req", s_req, 1'b0);
    check("rst_valid", s_valid, 1'b0);
    check("rst_outst", s_outst, 3'd0);
    resetn = 1'b1;
    exp_issue = RESET_PC; exp_deliv = RESET_PC;
    halted = 1'b0; prev_stall = 1'b0;
    deliv_cnt = 0; acc_cnt = 0; max_outst = 0;
    got_acc = 1'b0; got_hs = 1'b0;
  endtask

  task automatic redirect(input logic ex, input logic er, input logic br,
                          input logic [31:0] t_ex, input logic [31:0] t_er, input logic [31:0] t_br);
    wb_ex = ex; ertn_flush = er; br_taken = br;
    ex_entry = t_ex; ertn_entry = t_er; br_target = t_br;
    tick();
    wb_ex = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    int d0, a0;
    logic [31:0] tgt;
    fif.ds_allowin = 1'b1;
    fif.inst_sram_addr_ok = 1'b0;
    fif.inst_sram_data_ok = 1'b0;
    fif.inst_sram_rdata = '0;

    // Fill with decode blocked, then release: {allowin, req, addr, valid, pc, outst}
    tbl[0]  = '{1'b0, 1'b1, 32'h1c000000, 1'b0, 32'h0,        0};
    tbl[1]  = '{1'b0, 1'b1, 32'h1c000004, 1'b0, 32'h0,        1};
    tbl[2]  = '{1'b0, 1'b1, 32'h1c000008, 1'b1, 32'h1c000000, 1};
    tbl[3]  = '{1'b0, 1'b1, 32'h1c00000c, 1'b1, 32'h1c000000, 1};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1c000000, 1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1c000000, 0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000000, 0};
    tbl[7]  = '{1'b1, 1'b1, 32'h1c000010, 1'b1, 32'h1c000004, 0};
    tbl[8]  = '{1'b1, 1'b1, 32'h1c000014, 1'b1, 32'h1c000008, 1};
    tbl[9]  = '{1'b1, 1'b1, 32'h1c000018, 1'b1, 32'h1c00000c, 1};
    tbl[10] = '{1'b1, 1'b1, 32'h1c00001c, 1'b1, 32'h1c000010, 1};
    tbl[11] = '{1'b1, 1'b1, 32'h1c000020, 1'b1, 32'h1c000014, 1};

    // Steady stream: one instruction per cycle from the third cycle on
    do_reset();
    run(20);
    check("stream_deliv_cnt", deliv_cnt, 18);
    check("stream_max_outst", max_outst, 1);

    do_reset();
    foreach (tbl[i]) begin
      fif.ds_allowin = tbl[i].allowin;
      tick();
      check("tbl_req", s_req, tbl[i].req);
      if (tbl[i].req) check("tbl_addr", s_addr, tbl[i].addr);
      check("tbl_valid", s_valid, tbl[i].valid);
      if (tbl[i].valid) check("tbl_pc", s_bus[31:0], tbl[i].pc);
      check("tbl_outst", s_outst, tbl[i].outst);
    end

    // Slow SRAM: credits saturate at MAX_OUTST
    do_reset();
    lat_min = 6; lat_max = 6;
    run(40);
    check("slow_max_outst", max_outst, MAX_OUTST);
    check("slow_progress", deliv_cnt >= 8, 1'b1);

    // Branch with 3 pending, then a second branch before the stale responses drain
    do_reset();
    run(3);
    check("br_pending3", outst_cnt, 3'd3);
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1c000100);
    run(4);
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1c000200);
    run(30);
    check("br2_first_pc", first_pc, 32'h1c000200);
    check("br2_first_acc", first_acc, 32'h1c000200);

    // Redirect priority
    lat_min = 1; lat_max = 1;
    do_reset();
    run(4);
    redirect(1'b1, 1'b0, 1'b1, 32'h1c008000, 32'h0, 32'h1c000100);
    run(4);
    check("prio_ex_acc", first_acc, 32'h1c008000);
    check("prio_ex_pc", first_pc, 32'h1c008000);
    redirect(1'b0, 1'b1, 1'b1, 32'h0, 32'h1c004000, 32'h1c000100);
    run(4);
    check("prio_ertn_acc", first_acc, 32'h1c004000);

    // Misaligned branch target: one ADEF entry, then halt until an exception redirect
    do_reset();
    run(4);
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1c000102);
    d0 = deliv_cnt; a0 = acc_cnt;
    run(10);
    check("adef_pc", first_pc, 32'h1c000102);
    check("adef_bit", first_adef, 1'b1);
    check("halt_one_entry", deliv_cnt - d0, 1);
    check("halt_no_req", acc_cnt - a0, 0);
    redirect(1'b1, 1'b0, 1'b0, 32'h1c008000, 32'h0, 32'h0);
    run(6);
    check("resume_acc", first_acc, 32'h1c008000);
    check("resume_pc", first_pc, 32'h1c008000);

    // Randomized traffic with a mid-run reset
    do_reset();
    aok_pct = 70; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      fif.ds_allowin = ($urandom_range(3) != 0);
      br_stall = ($urandom_range(15) == 0);
      if ($urandom_range(39) == 0) begin
        tgt = {16'h1c00, 14'($urandom), 2'b00};
        if ($urandom_range(7) == 0) tgt[1] = 1'b1;
        redirect(1'($urandom), 1'($urandom), 1'b1, tgt, tgt ^ 32'h40, tgt ^ 32'h80);
      end else begin
        tick();
      end
    end
    br_stall = 1'b0;
    check("rand_progress", deliv_cnt > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
